// File: rtl/forth_bus_pkg.sv
// forth_bus_pkg
//   Shared constants for the Forth CPU bus responder: register addresses,
//   bus FSM state encoding, interrupt numbers and timer control bit positions.
//   Also holds the interrupt-acknowledge decode helper.
package forth_bus_pkg;

  localparam logic [15:0] ADDR_TMR_RELOAD = 16'hFF00;
  localparam logic [15:0] ADDR_TMR_CTRL   = 16'hFF01;
  localparam logic [15:0] ADDR_TMR_COUNT  = 16'hFF02;
  localparam logic [15:0] ADDR_GPIO_OUT   = 16'hFF03;
  localparam logic [15:0] ADDR_GPIO_IN    = 16'hFF04;
  localparam logic [15:0] ADDR_PENDING    = 16'hFF05;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_DONE  = 2'd3
  } bus_state_t;

  // interrupt_ack encoding: in-service interrupt number
  localparam logic [1:0] IRQ_NONE  = 2'd0;
  localparam logic [1:0] IRQ_TIMER = 2'd1;
  localparam logic [1:0] IRQ_EXT   = 2'd2;

  localparam int TMR_CTRL_EN   = 0;
  localparam int TMR_CTRL_AUTO = 1;

  // A pending bit is cleared only on the 0 -> n+1 transition of the
  // acknowledge number, never while it is merely held.
  function automatic logic [1:0] ack_clear(input logic [1:0] ack_prev,
                                           input logic [1:0] ack_now);
    ack_clear = 2'b00;
    if (ack_prev == IRQ_NONE) begin
      ack_clear[0] = (ack_now == IRQ_TIMER);
      ack_clear[1] = (ack_now == IRQ_EXT);
    end
  endfunction

endpackage

// File: rtl/forth_timer.sv
// forth_timer
//   Down-counting interval timer with reload register and control register
//   (bit0 enable, bit1 auto-reload). fire is high for the cycle in which an
//   enabled timer sits at terminal count 0; period is reload+1 cycles.
// Ports:
//   clk, nreset  clock, asynchronous active-low reset
//   wr_reload    write strobe: reload <= wdata, count <= wdata
//   wr_ctrl      write strobe: ctrl <= wdata[1:0]; enable 0->1 loads count
//   wdata        write data from the bus
//   reload       reload register
//   ctrl         control register
//   count        current count
//   fire         terminal-count pulse
module forth_timer
  import forth_bus_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             wr_reload,
  input  logic             wr_ctrl,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] reload,
  output logic [1:0]       ctrl,
  output logic [WIDTH-1:0] count,
  output logic             fire
);

  assign fire = ctrl[TMR_CTRL_EN] && (count == '0);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      reload <= '0;
      ctrl   <= '0;
      count  <= '0;
    end else begin
      if (wr_reload) begin
        reload <= wdata;
        count  <= wdata;
      end else if (wr_ctrl) begin
        ctrl <= wdata[1:0];
        if (!ctrl[TMR_CTRL_EN] && wdata[TMR_CTRL_EN])
          count <= reload;
      end else if (fire) begin
        if (ctrl[TMR_CTRL_AUTO])
          count <= reload;
        else
          ctrl[TMR_CTRL_EN] <= 1'b0;
      end else if (ctrl[TMR_CTRL_EN]) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/forth_bus_responder.sv
// forth_bus_responder
//   Memory/peripheral responder for a Forth CPU bus: RAM, interval timer,
//   GPIO and a two-source interrupt pending register, with configurable
//   wait states and a bus_fault pulse on unmapped accesses.
// Ports:
//   clk, nreset    clock, asynchronous active-low reset
//   mem_address    transaction address
//   mem_data_out   write data from CPU
//   mem_data_in    read data to CPU (valid while mem_ready=1)
//   mem_valid      request, held until mem_ready seen
//   mem_nwr        1=read, 0=write
//   mem_ready      one-cycle completion pulse
//   interrupt      pending bits: [0] timer, [1] external
//   interrupt_ack  CPU in-service number (0 none, 1 timer, 2 external)
//   ext_irq        asynchronous external interrupt request
//   gpio_out       GPIO output register
//   gpio_in        GPIO inputs (asynchronous)
//   bus_fault      one-cycle pulse with mem_ready on unmapped access
//
// Bus FSM:
//   state    | meaning
//   ST_IDLE  | waiting for mem_valid; latches the request
//   ST_WAIT  | counting down wait states
//   ST_READY | mem_ready high for one cycle; writes commit on its closing edge
//   ST_DONE  | waiting for mem_valid to drop
module forth_bus_responder
  import forth_bus_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int RAM_BITS    = 8,
  parameter int WAIT_STATES = 1,
  parameter int GPIO_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [WIDTH-1:0]      mem_address,
  input  logic [WIDTH-1:0]      mem_data_out,
  output logic [WIDTH-1:0]      mem_data_in,
  input  logic                  mem_valid,
  input  logic                  mem_nwr,
  output logic                  mem_ready,
  output logic [1:0]            interrupt,
  input  logic [1:0]            interrupt_ack,
  input  logic                  ext_irq,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic                  bus_fault
);

  localparam int RAM_WORDS = 1 << RAM_BITS;

  bus_state_t       state;
  logic [3:0]       wait_cnt;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             nwr_q;

  logic [WIDTH-1:0] ram [RAM_WORDS];

  logic [WIDTH-1:0] tmr_reload;
  logic [1:0]       tmr_ctrl;
  logic [WIDTH-1:0] tmr_count;
  logic             tmr_fire;

  logic [2:0]            ext_sync;
  logic [GPIO_WIDTH-1:0] gpi_s1;
  logic [GPIO_WIDTH-1:0] gpi_s2;
  logic [1:0]            ack_q;
  logic [1:0]            irq_set;

  logic [WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             sel_ram;
  logic             sel_reload;
  logic             sel_ctrl;
  logic             sel_count;
  logic             sel_gpo;
  logic             sel_gpi;
  logic             sel_pend;
  logic             mapped;
  logic             wr_en;

  // Decode the live address while idle (needed when WAIT_STATES=0 jumps
  // straight to READY) and the latched address otherwise.
  always_comb begin
    rd_addr    = (state == ST_IDLE) ? mem_address : addr_q;
    sel_ram    = (rd_addr >> RAM_BITS) == '0;
    sel_reload = rd_addr == WIDTH'(ADDR_TMR_RELOAD);
    sel_ctrl   = rd_addr == WIDTH'(ADDR_TMR_CTRL);
    sel_count  = rd_addr == WIDTH'(ADDR_TMR_COUNT);
    sel_gpo    = rd_addr == WIDTH'(ADDR_GPIO_OUT);
    sel_gpi    = rd_addr == WIDTH'(ADDR_GPIO_IN);
    sel_pend   = rd_addr == WIDTH'(ADDR_PENDING);
    mapped     = sel_ram | sel_reload | sel_ctrl | sel_count |
                 sel_gpo | sel_gpi | sel_pend;
    rd_data    = '0;
    if (sel_ram)         rd_data = ram[rd_addr[RAM_BITS-1:0]];
    else if (sel_reload) rd_data = tmr_reload;
    else if (sel_ctrl)   rd_data = WIDTH'(tmr_ctrl);
    else if (sel_count)  rd_data = tmr_count;
    else if (sel_gpo)    rd_data = WIDTH'(gpio_out);
    else if (sel_gpi)    rd_data = WIDTH'(gpi_s2);
    else if (sel_pend)   rd_data = WIDTH'(interrupt);
  end

  assign wr_en = (state == ST_READY) && !nwr_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      nwr_q       <= 1'b1;
      mem_ready   <= 1'b0;
      mem_data_in <= '0;
      bus_fault   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_valid) begin
            addr_q   <= mem_address;
            wdata_q  <= mem_data_out;
            nwr_q    <= mem_nwr;
            wait_cnt <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state       <= ST_READY;
              mem_ready   <= 1'b1;
              mem_data_in <= rd_data;
              bus_fault   <= ~mapped;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          // Counter reaches 0 on this edge: enter READY with data registered.
          if (wait_cnt == 4'd1) begin
            state       <= ST_READY;
            mem_ready   <= 1'b1;
            mem_data_in <= rd_data;
            bus_fault   <= ~mapped;
          end
        end
        ST_READY: begin
          state     <= ST_DONE;
          mem_ready <= 1'b0;
          bus_fault <= 1'b0;
        end
        ST_DONE: begin
          if (!mem_valid)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM has no reset; writes only commit from READY, which reset leaves.
  always_ff @(posedge clk) begin
    if (wr_en && sel_ram)
      ram[rd_addr[RAM_BITS-1:0]] <= wdata_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      gpio_out <= '0;
    else if (wr_en && sel_gpo)
      gpio_out <= wdata_q[GPIO_WIDTH-1:0];
  end

  forth_timer #(
    .WIDTH(WIDTH)
  ) u_timer (
    .clk      (clk),
    .nreset   (nreset),
    .wr_reload(wr_en && sel_reload),
    .wr_ctrl  (wr_en && sel_ctrl),
    .wdata    (wdata_q),
    .reload   (tmr_reload),
    .ctrl     (tmr_ctrl),
    .count    (tmr_count),
    .fire     (tmr_fire)
  );

  // ext_sync[1] is the synchronised request, ext_sync[2] its previous value.
  assign irq_set = {ext_sync[1] & ~ext_sync[2], tmr_fire};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ext_sync  <= '0;
      gpi_s1    <= '0;
      gpi_s2    <= '0;
      ack_q     <= IRQ_NONE;
      interrupt <= '0;
    end else begin
      ext_sync  <= {ext_sync[1:0], ext_irq};
      gpi_s1    <= gpio_in;
      gpi_s2    <= gpi_s1;
      ack_q     <= interrupt_ack;
      // A new event in the acknowledge cycle keeps the bit set.
      interrupt <= (interrupt & ~ack_clear(ack_q, interrupt_ack)) | irq_set;
    end
  end

endmodule

// File: tb/tb_forth_bus_responder.sv
module tb_forth_bus_responder;

  localparam int WIDTH       = 16;
  localparam int RAM_BITS    = 8;
  localparam int WAIT_STATES = 1;
  localparam int GPIO_WIDTH  = 8;

  logic                  clk = 1'b0;
  logic                  nreset = 1'b0;
  logic [WIDTH-1:0]      mem_address = '0;
  logic [WIDTH-1:0]      mem_data_out = '0;
  logic [WIDTH-1:0]      mem_data_in;
  logic                  mem_valid = 1'b0;
  logic                  mem_nwr = 1'b1;
  logic                  mem_ready;
  logic [1:0]            interrupt;
  logic [1:0]            interrupt_ack = 2'd0;
  logic                  ext_irq = 1'b0;
  logic [GPIO_WIDTH-1:0] gpio_out;
  logic [GPIO_WIDTH-1:0] gpio_in = '0;
  logic                  bus_fault;

  always #5 clk = ~clk;

  forth_bus_responder #(
    .WIDTH(WIDTH), .RAM_BITS(RAM_BITS),
    .WAIT_STATES(WAIT_STATES), .GPIO_WIDTH(GPIO_WIDTH)
  ) dut (
    .clk(clk), .nreset(nreset),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_valid(mem_valid), .mem_nwr(mem_nwr),
    .mem_ready(mem_ready), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .ext_irq(ext_irq),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .bus_fault(bus_fault)
  );

  int checks = 0;
  int errors = 0;
  int ready_pulses = 0;
  int xfers = 0;

  logic [15:0] ram_m [256];
  logic [7:0]  gpo_m;

  always @(negedge clk) if (mem_ready === 1'b1) ready_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One complete bus transaction; returns once the responder is idle again.
  task automatic xfer(input logic [15:0] a, input logic [15:0] d, input logic nwr,
                      output logic [15:0] rdata, output logic fault);
    int lat;
    mem_address = a; mem_data_out = d; mem_nwr = nwr; mem_valid = 1'b1;
    lat = 0;
    while (mem_ready !== 1'b1 && lat < 20) begin tick(1); lat++; end
    chk("ready_latency", lat, WAIT_STATES + 1);
    rdata = mem_data_in;
    fault = bus_fault;
    mem_valid = 1'b0;
    tick(1);
    chk("ready_one_cycle", mem_ready, 0);
    chk("fault_one_cycle", bus_fault, 0);
    tick(1);
    xfers++;
  endtask

  logic [15:0] rd, a16, d16, v;
  logic        f, nwr_r;
  int          n, op, r;

  initial begin
    // reset state
    tick(3);
    @(negedge clk); nreset = 1'b1;
    tick(1);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_bus_fault", bus_fault, 0);
    chk("rst_interrupt", interrupt, 0);
    chk("rst_gpio_out", gpio_out, 0);
    gpo_m = 8'h00;
    xfer(16'hFF00, 16'h0, 1'b1, rd, f); chk("rst_reload", rd, 0);
    xfer(16'hFF01, 16'h0, 1'b1, rd, f); chk("rst_ctrl", rd, 0);
    xfer(16'hFF02, 16'h0, 1'b1, rd, f); chk("rst_count", rd, 0);
    xfer(16'hFF05, 16'h0, 1'b1, rd, f); chk("rst_pending", rd, 0);

    // basic RAM write/read
    xfer(16'h0010, 16'h1234, 1'b0, rd, f); chk("wr10_fault", f, 0);
    xfer(16'h0010, 16'h0, 1'b1, rd, f);    chk("rd10_data", rd, 16'h1234);

    // fill RAM so every later read has a defined expectation
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      xfer(16'(i), v, 1'b0, rd, f);
      ram_m[i] = v;
    end

    // randomized traffic against the model
    for (int it = 0; it < 200; it++) begin
      op  = $urandom_range(0, 6);
      a16 = 16'($urandom);
      d16 = 16'($urandom);
      case (op)
        0: begin
          a16 = {8'h00, a16[7:0]};
          xfer(a16, d16, 1'b0, rd, f);
          ram_m[a16[7:0]] = d16;
          chk("ram_wr_fault", f, 0);
        end
        1: begin
          a16 = {8'h00, a16[7:0]};
          xfer(a16, 16'h0, 1'b1, rd, f);
          chk("ram_rd", rd, ram_m[a16[7:0]]);
          chk("ram_rd_fault", f, 0);
        end
        2: begin
          xfer(16'hFF03, d16, 1'b0, rd, f);
          gpo_m = d16[7:0];
          chk("gpo_wr", gpio_out, gpo_m);
        end
        3: begin
          xfer(16'hFF03, 16'h0, 1'b1, rd, f);
          chk("gpo_rd", rd, {8'h00, gpo_m});
        end
        4: begin
          gpio_in = d16[7:0];
          tick(2);
          xfer(16'hFF04, 16'h0, 1'b1, rd, f);
          chk("gpi_rd", rd, {8'h00, d16[7:0]});
        end
        5: begin
          if (a16[0]) a16 = 16'(16'h0100 + $urandom_range(0, 16'hFDFF));
          else        a16 = 16'(16'hFF06 + $urandom_range(0, 16'h00F9));
          nwr_r = d16[0];
          xfer(a16, d16, nwr_r, rd, f);
          chk("unmapped_fault", f, 1);
          if (nwr_r) chk("unmapped_rd_zero", rd, 0);
          chk("unmapped_wr_ignored", gpio_out, gpo_m);
        end
        default: begin
          xfer(16'hFF00, d16, 1'b0, rd, f);
          xfer(16'hFF02, 16'h0, 1'b1, rd, f);
          chk("reload_loads_count", rd, d16);
          xfer(16'hFF00, 16'h0, 1'b1, rd, f);
          chk("reload_rd", rd, d16);
        end
      endcase
    end

    // control register truncation
    xfer(16'hFF01, 16'hFFF2, 1'b0, rd, f);
    xfer(16'hFF01, 16'h0, 1'b1, rd, f);
    chk("ctrl_truncate", rd, 16'h0002);
    xfer(16'hFF01, 16'h0000, 1'b0, rd, f);

    // one-shot timer, reload 4: fires 5 cycles after enable commits
    xfer(16'hFF00, 16'h0004, 1'b0, rd, f);
    xfer(16'hFF01, 16'h0001, 1'b0, rd, f);
    n = 1;
    while (interrupt[0] !== 1'b1 && n < 15) begin tick(1); n++; end
    chk("oneshot_delay", n, 5);
    xfer(16'hFF01, 16'h0, 1'b1, rd, f);
    chk("oneshot_enable_cleared", rd, 0);
    interrupt_ack = 2'd1; tick(1); interrupt_ack = 2'd0; tick(1);
    chk("timer_ack_clear", interrupt, 0);

    // auto-reload timer, reload 2: period 3
    xfer(16'hFF00, 16'h0002, 1'b0, rd, f);
    xfer(16'hFF01, 16'h0003, 1'b0, rd, f);
    n = 1;
    while (interrupt[0] !== 1'b1 && n < 15) begin tick(1); n++; end
    chk("auto_first_fire", n, 3);
    interrupt_ack = 2'd1; tick(1);
    chk("auto_ack_clears", interrupt[0], 0);
    interrupt_ack = 2'd0; tick(1);
    chk("auto_between_fires", interrupt[0], 0);
    tick(1);
    chk("auto_refire", interrupt[0], 1);
    interrupt_ack = 2'd1; tick(1);
    chk("auto_ack_clears2", interrupt[0], 0);
    interrupt_ack = 2'd0; tick(1);
    chk("auto_between_fires2", interrupt[0], 0);
    interrupt_ack = 2'd1; tick(1);
    chk("event_wins_over_ack", interrupt[0], 1);
    interrupt_ack = 2'd0; tick(1);
    chk("ack_release_no_effect", interrupt[0], 1);
    xfer(16'hFF01, 16'h0000, 1'b0, rd, f);
    interrupt_ack = 2'd1; tick(1); interrupt_ack = 2'd0; tick(1);
    chk("timer_stopped_cleared", interrupt, 0);

    // external interrupt
    ext_irq = 1'b1;
    n = 0;
    while (interrupt[1] !== 1'b1 && n < 10) begin
      tick(1); n++;
      if (n == 2) ext_irq = 1'b0;
    end
    ext_irq = 1'b0;
    chk("ext_latency_le3", (n >= 1 && n <= 3), 1);
    interrupt_ack = 2'd2; tick(1);
    chk("ext_ack_clears", interrupt[1], 0);
    ext_irq = 1'b1; tick(2); ext_irq = 1'b0; tick(3);
    chk("ext_set_ack_held", interrupt[1], 1);
    interrupt_ack = 2'd0; tick(1);
    chk("ext_ack_release", interrupt[1], 1);
    chk("ext_no_timer", interrupt[0], 0);

    // both pending together, random one-shot period
    r = $urandom_range(0, 7);
    xfer(16'hFF00, 16'(r), 1'b0, rd, f);
    xfer(16'hFF01, 16'h0001, 1'b0, rd, f);
    n = 1;
    while (interrupt[0] !== 1'b1 && n < 15) begin tick(1); n++; end
    chk("rand_oneshot_delay", n, r + 1);
    chk("both_pending", interrupt, 2'b11);
    xfer(16'hFF05, 16'h0, 1'b1, rd, f);
    chk("pending_rd", rd, 16'h0003);
    interrupt_ack = 2'd1; tick(1); interrupt_ack = 2'd0; tick(1);
    chk("ack_timer_only", interrupt, 2'b10);
    interrupt_ack = 2'd2; tick(1); interrupt_ack = 2'd0; tick(1);
    chk("ack_ext_only", interrupt, 2'b00);

    // unmapped read and GPIO write
    xfer(16'h8000, 16'h0, 1'b1, rd, f);
    chk("rd8000_data", rd, 0);
    chk("rd8000_fault", f, 1);
    xfer(16'hFF03, 16'h00A5, 1'b0, rd, f);
    gpo_m = 8'hA5;
    chk("gpo_a5", gpio_out, 8'hA5);

    // reset during WAIT of a write: abandoned, no write, no ready
    n = ready_pulses;
    mem_address = 16'h0020; mem_data_out = ~ram_m[32]; mem_nwr = 1'b0; mem_valid = 1'b1;
    tick(1);
    #2 nreset = 1'b0; mem_valid = 1'b0;
    tick(2);
    @(negedge clk); nreset = 1'b1;
    tick(2);
    chk("abort_no_ready", ready_pulses, n);
    chk("abort_gpio_reset", gpio_out, 0);
    xfer(16'h0020, 16'h0, 1'b1, rd, f);
    chk("abort_ram_unchanged", rd, ram_m[32]);

    // reset during WAIT of a read with mem_valid held: re-accepted afterwards
    mem_address = 16'h0020; mem_nwr = 1'b1; mem_valid = 1'b1;
    tick(1);
    #2 nreset = 1'b0;
    tick(1);
    @(negedge clk); nreset = 1'b1;
    xfer(16'h0020, 16'h0, 1'b1, rd, f);
    chk("reaccept_rd", rd, ram_m[32]);

    chk("ready_pulse_count", ready_pulses, xfers);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
